// File: rtl/ready_wq_pkg.sv
// ready_wq_pkg: shared types and defaults for the ready-table write queue.
//   PREG_W      - physical register index width
//   NUM_LK      - forwarding lookup ports (one per ready-table read port)
//   rwq_entry_t - queued write: {preg, val}
//   rwq_state_e - sequencer state: INIT sweep, then RUN drain
package ready_wq_pkg;

    localparam int PREG_W = 6;
    localparam int NUM_LK = 7;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic              val;
    } rwq_entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rwq_state_e;

endpackage

// File: rtl/ready_wq_match.sv
// ready_wq_match: one forwarding lookup port. Finds the youngest pending write
// to lk_preg_i among the queue entries and this cycle's incoming requests.
//   lk_preg_i  - looked-up preg
//   q_valid_i  - queue slot occupancy, age ordered (bit 0 = head, oldest)
//   q_preg_i   - queue pregs, age ordered, PREG_W bits per slot
//   q_val_i    - queue values, age ordered
//   in_valid_i - accepted incoming requests: [0]=alloc, [1]=wb0, [2]=wb1
//   in_preg_i  - incoming pregs, same order
//   in_val_i   - incoming values, same order
//   hit_o      - some pending write targets lk_preg_i
//   val_o      - value of the youngest such write (meaningful when hit_o)
module ready_wq_match #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6
) (
    input  logic [PREG_W-1:0]       lk_preg_i,
    input  logic [DEPTH-1:0]        q_valid_i,
    input  logic [DEPTH*PREG_W-1:0] q_preg_i,
    input  logic [DEPTH-1:0]        q_val_i,
    input  logic [2:0]              in_valid_i,
    input  logic [3*PREG_W-1:0]     in_preg_i,
    input  logic [2:0]              in_val_i,
    output logic                    hit_o,
    output logic                    val_o
);

    // Scan oldest to youngest; later matches overwrite earlier ones.
    always_comb begin
        hit_o = 1'b0;
        val_o = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (q_valid_i[k] && (q_preg_i[k*PREG_W +: PREG_W] == lk_preg_i)) begin
                hit_o = 1'b1;
                val_o = q_val_i[k];
            end
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (in_valid_i[i] && (in_preg_i[i*PREG_W +: PREG_W] == lk_preg_i)) begin
                hit_o = 1'b1;
                val_o = in_val_i[i];
            end
        end
    end

endmodule

// File: rtl/ready_wq.sv
// ready_wq: write queue and write-port sequencer for the physical-register
// ready table. After reset sweeps every entry to ready, then drains queued
// alloc (write 0) and wakeup (write 1) requests one per cycle into the RAM.
//   clk, rst        - clock, asynchronous active-high reset
//   alloc_*         - rename allocation request / accept
//   wb_valid_i/preg - two writeback wakeups, never backpressured
//   ram_*           - RAM write port (WEN, AW, DI)
//   lk_preg_i       - RAM read addresses; lk_hit_o/lk_val_o forward pending writes
//   init_done_o     - sweep finished
//   ovf_o           - sticky: a wakeup was dropped on a full queue
module ready_wq #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = ready_wq_pkg::PREG_W,
    parameter int NUM_LK = ready_wq_pkg::NUM_LK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid_i,
    input  logic [PREG_W-1:0]        alloc_preg_i,
    output logic                     alloc_ready_o,
    input  logic [1:0]               wb_valid_i,
    input  logic [2*PREG_W-1:0]      wb_preg_i,
    output logic                     ram_wen_o,
    output logic [PREG_W-1:0]        ram_aw_o,
    output logic                     ram_di_o,
    input  logic [NUM_LK*PREG_W-1:0] lk_preg_i,
    output logic [NUM_LK-1:0]        lk_hit_o,
    output logic [NUM_LK-1:0]        lk_val_o,
    output logic                     init_done_o,
    output logic                     ovf_o
);

    import ready_wq_pkg::*;

    localparam int AW = $clog2(DEPTH);

    rwq_state_e        state_q, state_d;
    logic [PREG_W-1:0] sweep_q, sweep_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    rwq_entry_t        mem_q [DEPTH];
    rwq_entry_t        mem_d [DEPTH];

    logic              pop;
    logic              alloc_acc;
    logic              wb0_acc, wb1_acc;
    logic [AW:0]       free_slots;
    logic [AW:0]       avail;
    logic [2:0]        in_v;
    rwq_entry_t        in_e [3];
    logic [1:0]        n_push;
    logic [AW-1:0]     wr_ptr;

    // Flattened, age-ordered views for the lookup ports.
    logic [DEPTH-1:0]        q_vld_f;
    logic [DEPTH*PREG_W-1:0] q_preg_f;
    logic [DEPTH-1:0]        q_val_f;
    logic [3*PREG_W-1:0]     in_preg_f;
    logic [2:0]              in_val_f;
    logic [NUM_LK-1:0]       m_hit, m_val;

    rwq_entry_t head_e;
    assign head_e = mem_q[head_q];

    // Acceptance uses only registered count, so no valid->ready path.
    assign alloc_ready_o = (state_q == RUN) && (cnt_q <= (AW+1)'(DEPTH - 3));
    assign alloc_acc     = alloc_valid_i && alloc_ready_o;
    assign pop           = (state_q == RUN) && (cnt_q != '0);

    // Alloc acceptance guarantees three free slots, so alloc always fits;
    // wakeups take what is left, wb[1] losing first.
    assign free_slots = (AW+1)'(DEPTH) - cnt_q + (AW+1)'(pop);
    assign avail      = free_slots - (AW+1)'(alloc_acc);
    assign wb0_acc    = wb_valid_i[0] && (avail != '0);
    assign wb1_acc    = wb_valid_i[1] && (avail > (AW+1)'(wb0_acc));

    assign in_v    = {wb1_acc, wb0_acc, alloc_acc};
    assign in_e[0] = rwq_entry_t'({alloc_preg_i, 1'b0});
    assign in_e[1] = rwq_entry_t'({wb_preg_i[PREG_W-1:0], 1'b1});
    assign in_e[2] = rwq_entry_t'({wb_preg_i[2*PREG_W-1:PREG_W], 1'b1});
    assign n_push  = 2'(in_v[0]) + 2'(in_v[1]) + 2'(in_v[2]);

    always_comb begin
        mem_d  = mem_q;
        wr_ptr = tail_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (in_v[i]) begin
                mem_d[wr_ptr] = in_e[i];
                wr_ptr        = wr_ptr + AW'(1);
            end
        end
        tail_d  = wr_ptr;
        head_d  = pop ? head_q + AW'(1) : head_q;
        cnt_d   = cnt_q + (AW+1)'(n_push) - (AW+1)'(pop);
        ovf_d   = ovf_q | (wb_valid_i[0] & ~wb0_acc) | (wb_valid_i[1] & ~wb1_acc);
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + PREG_W'(1);
            if (sweep_q == '1) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ram_wen_o   = (state_q == INIT) ? 1'b1 : (cnt_q != '0);
    assign ram_aw_o    = (state_q == INIT) ? sweep_q : head_e.preg;
    assign ram_di_o    = (state_q == INIT) ? 1'b1 : head_e.val;
    assign init_done_o = (state_q == RUN);
    assign ovf_o       = ovf_q;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            q_preg_f[k*PREG_W +: PREG_W] = mem_q[head_q + AW'(k)].preg;
            q_val_f[k]                   = mem_q[head_q + AW'(k)].val;
            q_vld_f[k]                   = (k < 32'(cnt_q));
        end
        for (int unsigned i = 0; i < 3; i++) begin
            in_preg_f[i*PREG_W +: PREG_W] = in_e[i].preg;
            in_val_f[i]                   = in_e[i].val;
        end
    end

    for (genvar p = 0; p < NUM_LK; p++) begin : g_lk
        ready_wq_match #(
            .DEPTH  (DEPTH),
            .PREG_W (PREG_W)
        ) u_match (
            .lk_preg_i  (lk_preg_i[p*PREG_W +: PREG_W]),
            .q_valid_i  (q_vld_f),
            .q_preg_i   (q_preg_f),
            .q_val_i    (q_val_f),
            .in_valid_i (in_v),
            .in_preg_i  (in_preg_f),
            .in_val_i   (in_val_f),
            .hit_o      (m_hit[p]),
            .val_o      (m_val[p])
        );
    end

    // During the sweep every entry is about to become ready.
    assign lk_hit_o = (state_q == INIT) ? '1 : m_hit;
    assign lk_val_o = (state_q == INIT) ? '1 : m_val;

endmodule

// File: tb/tb_ready_wq.sv
module tb_ready_wq;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [5:0]  alloc_preg;
    logic        alloc_ready;
    logic [1:0]  wb_valid;
    logic [11:0] wb_preg;
    logic        ram_wen;
    logic [5:0]  ram_aw;
    logic        ram_di;
    logic [41:0] lk_preg;
    logic [6:0]  lk_hit;
    logic [6:0]  lk_val;
    logic        init_done;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    ready_wq #(
        .DEPTH  (8),
        .PREG_W (6),
        .NUM_LK (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_i (alloc_valid),
        .alloc_preg_i  (alloc_preg),
        .alloc_ready_o (alloc_ready),
        .wb_valid_i    (wb_valid),
        .wb_preg_i     (wb_preg),
        .ram_wen_o     (ram_wen),
        .ram_aw_o      (ram_aw),
        .ram_di_o      (ram_di),
        .lk_preg_i     (lk_preg),
        .lk_hit_o      (lk_hit),
        .lk_val_o      (lk_val),
        .init_done_o   (init_done),
        .ovf_o         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       av;
        logic [5:0] ap;
        logic [1:0] wv;
        logic [5:0] wp0;
        logic [5:0] wp1;
        logic [5:0] lkp;
        logic       wen;
        logic [5:0] aw;
        logic       di;
        logic       rdy;
        logic       hit;
        logic       val;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ports 0..5 look at lkp, port 6 at preg 63, which no test writes after the sweep.
    task automatic drive(input logic av, input logic [5:0] ap, input logic [1:0] wv,
                         input logic [5:0] wp0, input logic [5:0] wp1, input logic [5:0] lkp);
        alloc_valid = av;
        alloc_preg  = ap;
        wb_valid    = wv;
        wb_preg     = {wp1, wp0};
        lk_preg     = {6'd63, {6{lkp}}};
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wen"},   64'(ram_wen), 64'(1));
        chk({tag, "_aw"},    64'(ram_aw), 64'(0));
        chk({tag, "_di"},    64'(ram_di), 64'(1));
        chk({tag, "_rdy"},   64'(alloc_ready), 64'(0));
        chk({tag, "_hit"},   64'(lk_hit), 64'h7f);
        chk({tag, "_done"},  64'(init_done), 64'(0));
        chk({tag, "_ovf"},   64'(ovf), 64'(0));
    endtask

    // rst released #2 after a posedge; cycle k is checked #4 into it.
    task automatic sweep_and_check(input string tag);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k != 0) begin
                @(posedge clk);
                #2;
            end
            #2;
            chk($sformatf("%s_sweep%0d_wen", tag, k), 64'(ram_wen), 64'(1));
            chk($sformatf("%s_sweep%0d_aw", tag, k), 64'(ram_aw), 64'(k));
            chk($sformatf("%s_sweep%0d_di", tag, k), 64'(ram_di), 64'(1));
            chk($sformatf("%s_sweep%0d_done", tag, k), 64'(init_done), 64'(0));
            chk($sformatf("%s_sweep%0d_rdy", tag, k), 64'(alloc_ready), 64'(0));
        end
        @(posedge clk);
        #4;
        chk({tag, "_c64_done"}, 64'(init_done), 64'(1));
        chk({tag, "_c64_wen"},  64'(ram_wen), 64'(0));
        chk({tag, "_c64_rdy"},  64'(alloc_ready), 64'(1));
    endtask

    logic [5:0] seq_aw [12];
    logic       seq_di [12];

    initial begin
        vecs[0] = '{1'b1, 6'd5,  2'b11, 6'd9,  6'd12, 6'd12, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd12, 1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd12, 1'b1, 6'd9,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd12, 1'b1, 6'd12, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd12, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 6'd20, 2'b00, 6'd0,  6'd0,  6'd20, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 6'd0,  2'b01, 6'd20, 6'd0,  6'd20, 1'b1, 6'd20, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd20, 1'b1, 6'd20, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 6'd0,  2'b00, 6'd0,  6'd0,  6'd20, 0,    6'd0,  1'b0, 1'b1, 1'b0, 1'b0};

        // Expected drain order for the saturation run (wb[1] of the last
        // input cycle is the dropped one).
        seq_aw = '{6'd30, 6'd40, 6'd50, 6'd31, 6'd41, 6'd51,
                   6'd32, 6'd42, 6'd52, 6'd43, 6'd53, 6'd44};
        seq_di = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd0);
        @(posedge clk);
        #3;
        chk_reset_state("reset");

        sweep_and_check("init");

        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #4;
            chk($sformatf("idle%0d_wen", c), 64'(ram_wen), 64'(0));
        end

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #2;
            drive(vecs[i].av, vecs[i].ap, vecs[i].wv, vecs[i].wp0, vecs[i].wp1, vecs[i].lkp);
            #2;
            chk($sformatf("vec%0d_wen", i), 64'(ram_wen), 64'(vecs[i].wen));
            if (vecs[i].wen) begin
                chk($sformatf("vec%0d_aw", i), 64'(ram_aw), 64'(vecs[i].aw));
                chk($sformatf("vec%0d_di", i), 64'(ram_di), 64'(vecs[i].di));
            end
            chk($sformatf("vec%0d_rdy", i), 64'(alloc_ready), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d_hit", i), 64'(lk_hit), 64'({1'b0, {6{vecs[i].hit}}}));
            chk($sformatf("vec%0d_val", i), 64'(lk_val & lk_hit),
                64'({1'b0, {6{vecs[i].hit & vecs[i].val}}}));
        end

        // Saturation: alloc + both wakeups every cycle for five cycles.
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #2;
            if (c < 5)
                drive(1'b1, 6'(30 + c), 2'b11, 6'(40 + c), 6'(50 + c), 6'd54);
            else
                drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd54);
            #2;
            if (c < 5)
                chk($sformatf("sat%0d_rdy", c), 64'(alloc_ready), 64'(c < 3));
            chk($sformatf("sat%0d_ovf", c), 64'(ovf), 64'(c >= 5));
            chk($sformatf("sat%0d_hit54", c), 64'(lk_hit[0]), 64'(0));
            chk($sformatf("sat%0d_wen", c), 64'(ram_wen), 64'(c >= 1 && c <= 12));
            if (c >= 1 && c <= 12) begin
                chk($sformatf("sat%0d_aw", c), 64'(ram_aw), 64'(seq_aw[c-1]));
                chk($sformatf("sat%0d_di", c), 64'(ram_di), 64'(seq_di[c-1]));
            end
        end

        // Reset with four entries pending.
        @(posedge clk);
        #2 drive(1'b1, 6'd1, 2'b11, 6'd2, 6'd3, 6'd4);
        @(posedge clk);
        #2 drive(1'b0, 6'd0, 2'b11, 6'd4, 6'd5, 6'd4);
        @(posedge clk);
        #2 drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 6'd4);
        #1;
        chk("pend_wen", 64'(ram_wen), 64'(1));
        chk("pend_hit4", 64'(lk_hit[0]), 64'(1));
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        sweep_and_check("resweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ready_wq.md
# ready_wq

Write queue and write-port sequencer for the 64-entry physical-register ready table (the 7-read/1-write bit RAM). Collects one per-cycle "not ready" request from rename allocation and up to two per-cycle "ready" wakeups from writeback, buffers them in order, and drains one per cycle into the RAM's single write port. Provides per-read-port forwarding of pending writes so issue sees correct ready bits before the RAM is updated. After reset it sweeps all 64 entries to ready before accepting allocations.

## Interface
Parameters:
- `DEPTH`, 8, queue entries (power of two, ≥4)
- `PREG_W`, 6, physical register index width
- `NUM_LK`, 7, forwarding lookup ports (matches RAM read ports)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `alloc_valid_i` in 1: rename allocates preg (write 0)
- `alloc_preg_i` in PREG_W: allocated preg
- `alloc_ready_o` out 1: allocation accepted when high with valid
- `wb_valid_i` in 2: writeback wakeups (write 1), never backpressured
- `wb_preg_i` in 2×PREG_W: wakeup pregs
- `ram_wen_o` out 1: to RAM WEN
- `ram_aw_o` out PREG_W: to RAM AW
- `ram_di_o` out 1: to RAM DI
- `lk_preg_i` in NUM_LK×PREG_W: addresses driven to RAM read ports
- `lk_hit_o` out NUM_LK: pending write to that preg exists
- `lk_val_o` out NUM_LK: value of youngest pending write (valid when hit)
- `init_done_o` out 1: sweep complete
- `ovf_o` out 1: sticky, a wakeup was dropped on full queue

## Operation
- FSM states INIT, RUN. Reset → INIT, sweep counter 0, queue empty.
- INIT: `ram_wen_o`=1, `ram_aw_o`=sweep counter, `ram_di_o`=1; counter increments each cycle; after address 63 written → RUN. `alloc_ready_o`=0. Wakeups are still enqueued, drained only in RUN.
- RUN: head entry drives `ram_aw_o`/`ram_di_o`; `ram_wen_o`=queue non-empty; head popped on same edge.
- Enqueue order within a cycle: alloc (if accepted), then wb[0], then wb[1]; entry = {preg, value}. Enqueue and dequeue can occur in the same cycle; next count = count + pushes − pop.
- `alloc_ready_o` = RUN && (DEPTH − count) ≥ 3, from registered count only (no combinational path from valids).
- Wakeup arriving with no free slot (after same-cycle pop credit) is dropped in order, wb[1] before wb[0]; `ovf_o` set, cleared only by reset.
- Forwarding per lookup port: compare against all valid queue entries plus this cycle's incoming accepted requests; youngest match wins (incoming wb[1] > wb[0] > alloc > queue tail…head). Head entry being written this cycle still counts as pending. During INIT `lk_hit_o`=1, `lk_val_o`=1 for all ports.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Timing
- Reset values: `ram_wen_o`=1 (INIT), `ram_aw_o`=0, `ram_di_o`=1, `alloc_ready_o`=0, `lk_hit_o`=all 1, `init_done_o`=0, `ovf_o`=0.
- INIT lasts exactly 64 cycles after reset deassertion; `init_done_o` high from the first RUN cycle.
- Request accepted in cycle N: at earliest written to RAM at end of N+1 (empty queue); visible via `lk_*` from cycle N (combinational bypass).
- Steady throughput: 1 RAM write/cycle; sustained input above 1/cycle fills the queue.
- `lk_*` outputs are combinational from `lk_preg_i`, incoming requests and queue state; consumer muxes `lk_hit_o ? lk_val_o : RAM Q`.
- Reset mid-sweep or mid-drain: queue discarded, sweep restarts from 0.

## Structure
- Shared package: `PREG_W`, `NUM_LK`, typedef `rwq_entry_t` {preg, val}, enum `rwq_state_e` {INIT, RUN}.
- One sub-module: `ready_wq_match` — single-port youngest-match priority over queue + incoming entries, instantiated NUM_LK times by generate.
- Queue storage: flops, circular buffer with head/tail pointers.

## Test plan
- Reset, idle 70 cycles → AW 0..63 written with DI=1 on cycles 0–63, `init_done_o` rises on cycle 64, `ram_wen_o`=0 afterwards.
- RUN, alloc preg 5 + wb 9, 12 same cycle → RAM writes (5,0),(9,1),(12,1) on next three cycles; lk port 0 at preg 12 hits val 1 from the request cycle until its write cycle inclusive.
- Alloc preg 20 at N, wb 20 at N+1 → lk at 20 shows 0 in N, 1 from N+1; RAM final value 1.
- Hold wb both valid every cycle with alloc valid → `alloc_ready_o` drops when count > 5; after queue full, next wakeup sets `ovf_o`, stays 1 until reset.
- Assert `rst` with 4 entries pending during RUN → outputs return to reset values immediately, pending writes never reach RAM, sweep restarts at AW 0.
